// File: rtl/aes_defs.sv
// Shared AES definitions for the decryption core: FSM encoding, round count,
// Rcon table, GF(2^8) helpers and the InvShiftRows byte map.
package aes_defs;

  localparam int AES256_NR = 14;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_KEYEXP = 2'd1,
    ST_ROUNDS = 2'd2
  } fsm_e;

  // Rcon[j] feeds word 0 of round key 2j; index 0 is never selected.
  localparam logic [7:0] RCON [8] = '{
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
  };

  // Bytes are column-major (byte = 4*col + row); output byte i of
  // InvShiftRows comes from input byte INV_SR_MAP[i].
  localparam logic [3:0] INV_SR_MAP [16] = '{
    4'd0, 4'd13, 4'd10, 4'd7,
    4'd4, 4'd1,  4'd14, 4'd11,
    4'd8, 4'd5,  4'd2,  4'd15,
    4'd12, 4'd9, 4'd6,  4'd3
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gm0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gm0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gm0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[7:0];
    a1 = col[15:8];
    a2 = col[23:16];
    a3 = col[31:24];
    return {gm0b(a0) ^ gm0d(a1) ^ gm09(a2) ^ gm0e(a3),
            gm0d(a0) ^ gm09(a1) ^ gm0e(a2) ^ gm0b(a3),
            gm09(a0) ^ gm0e(a1) ^ gm0b(a2) ^ gm0d(a3),
            gm0e(a0) ^ gm0b(a1) ^ gm0d(a2) ^ gm09(a3)};
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse AES S-box lookup; sixteen copies form the InvSubBytes layer.
module aes_inv_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign data_o = INV_SBOX[data_i];

endmodule

// File: rtl/aes_sbox.sv
// Forward AES S-box, shared with the encryption side; used by the key schedule.
module aes_sbox (
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign data_o = SBOX[data_i];

endmodule

// File: rtl/aes256_decrypt_core.sv
// Iterative AES-256 inverse cipher: 13 cycles of key expansion into a round-key
// file, then 14 inverse rounds at one per cycle, ending in a one-cycle done pulse.
module aes256_decrypt_core
  import aes_defs::*;
#(
  parameter int NR = AES256_NR
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [255:0] key_i,
  input  logic [127:0] ciphertext,
  output logic [127:0] plaintext,
  output logic         done,
  output logic         busy
);

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   rnd_q, rnd_d;     // key index k in KEYEXP, round index r in ROUNDS
  logic [127:0] rk_q [NR+1];
  logic [127:0] rk_d [NR+1];
  logic [127:0] blk_q, blk_d;
  logic [127:0] pt_q, pt_d;
  logic         done_q, done_d;

  // ---------------- key schedule: one 128-bit round key per cycle
  logic [127:0] rk_prev, rk_prev2, key_next;
  logic [31:0]  ks_word, ks_sub, f0, w0, w1, w2, w3;
  logic         even_k;

  assign rk_prev  = rk_q[rnd_q - 4'd1];
  assign rk_prev2 = rk_q[rnd_q - 4'd2];
  assign even_k   = ~rnd_q[0];
  assign ks_word  = even_k ? {rk_prev[103:96], rk_prev[127:104]} : rk_prev[127:96];

  for (genvar g = 0; g < 4; g++) begin : g_ks_sbox
    aes_sbox u_sbox (
      .data_i (ks_word[8*g +: 8]),
      .data_o (ks_sub[8*g +: 8])
    );
  end

  assign f0       = ks_sub ^ (even_k ? {24'd0, RCON[rnd_q[3:1]]} : 32'd0);
  assign w0       = rk_prev2[31:0]   ^ f0;
  assign w1       = rk_prev2[63:32]  ^ w0;
  assign w2       = rk_prev2[95:64]  ^ w1;
  assign w3       = rk_prev2[127:96] ^ w2;
  assign key_next = {w3, w2, w1, w0};

  // ---------------- inverse round datapath
  logic [127:0] isr, isb, ark, imc;

  for (genvar g = 0; g < 16; g++) begin : g_round_sbox
    assign isr[8*g +: 8] = blk_q[8*int'(INV_SR_MAP[g]) +: 8];
    aes_inv_sbox u_inv_sbox (
      .data_i (isr[8*g +: 8]),
      .data_o (isb[8*g +: 8])
    );
  end

  assign ark = isb ^ rk_q[rnd_q];

  for (genvar c = 0; c < 4; c++) begin : g_inv_mix
    assign imc[32*c +: 32] = inv_mix_column(ark[32*c +: 32]);
  end

  // ---------------- FSM: state register / next state / outputs
  always_ff @(posedge clk) begin
    if (rst) fsm_q <= ST_IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    unique case (fsm_q)
      ST_IDLE:   if (start)               fsm_d = ST_KEYEXP;
      ST_KEYEXP: if (rnd_q == 4'(NR))     fsm_d = ST_ROUNDS;
      ST_ROUNDS: if (rnd_q == 4'd0)       fsm_d = ST_IDLE;
      default:                            fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (fsm_q != ST_IDLE);
  end

  // ---------------- datapath next state
  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rk_d   = rk_q;
    blk_d  = blk_q;
    rnd_d  = rnd_q;
    pt_d   = pt_q;
    done_d = 1'b0;
    unique case (fsm_q)
      ST_IDLE: begin
        if (start) begin
          blk_d    = ciphertext;
          rk_d[0]  = key_i[127:0];
          rk_d[1]  = key_i[255:128];
          rnd_d    = 4'd2;
        end
      end
      ST_KEYEXP: begin
        rk_d[rnd_q] = key_next;
        if (rnd_q == 4'(NR)) begin
          blk_d = blk_q ^ key_next;
          rnd_d = 4'(NR - 1);
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      ST_ROUNDS: begin
        if (rnd_q == 4'd0) begin
          blk_d  = ark;
          pt_d   = ark;
          done_d = 1'b1;
        end else begin
          blk_d  = imc;
          rnd_d  = rnd_q - 4'd1;
        end
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the round-key file is reset explicitly; an aborted block must not
      // leave key material visible in the registers.
      for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
      blk_q  <= '0;
      rnd_q  <= '0;
      pt_q   <= '0;
      done_q <= 1'b0;
    end else begin
      for (int i = 0; i <= NR; i++) rk_q[i] <= rk_d[i];
      blk_q  <= blk_d;
      rnd_q  <= rnd_d;
      pt_q   <= pt_d;
      done_q <= done_d;
    end
  end

  assign plaintext = pt_q;
  assign done      = done_q;

endmodule
